cdiv: RTL and testbench

CDIV -- requirements
Module: cdiv

---
 rtl/cdiv_pkg.sv | 31 +++
 rtl/cdiv_udiv.sv | 73 +++++++
 rtl/cdiv.sv | 150 +++++++++++++++
 tb/tb_cdiv.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdiv_pkg.sv
// Shared types and width helpers for the complex divider.
package cdiv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_PREP,
        S_DIV,
        S_DONE
    } state_e;

    // Width of the signed cross-product numerators.
    function automatic int nw_f(input int aw, input int bw);
        return aw + bw + 1;
    endfunction

    // Quotient bits produced serially; xb is the extra rounding bit (0 or 1).
    function automatic int iter_f(input int nw, input int frac, input int xb);
        return nw + frac + xb;
    endfunction

    // Saturation limits; callers keep the low ow bits.
    function automatic logic [63:0] sat_pos_f(input int ow);
        return (64'd1 << (ow - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_neg_f(input int ow);
        return ~sat_pos_f(ow);
    endfunction

endpackage

// File: rtl/cdiv_udiv.sv
// Unsigned serial restoring divider, one quotient bit per cycle.
// The start cycle already retires the first bit; quot is valid in the cycle done is high.
module cdiv_udiv #(
    parameter int NW = 33,
    parameter int DW = 32,
    parameter int SH = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NW-1:0]      dividend,
    input  logic [DW-1:0]      divisor,
    output logic               done,
    output logic [NW+SH-1:0]   quot
);
    localparam int QW = NW + SH;
    localparam int CW = $clog2(QW + 1);

    logic [DW-1:0] rem_q, rem_d, dsr_q, dsr_d, rem_in, dsr_in;
    logic [QW-1:0] qs_q, qs_d, qs_in;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d, ge;
    logic [DW:0]   trial;

    always_comb begin
        rem_in = start ? '0 : rem_q;
        qs_in  = start ? (QW'(dividend) << SH) : qs_q;
        dsr_in = start ? divisor : dsr_q;
        trial  = {rem_in, qs_in[QW-1]};
        ge     = (trial >= {1'b0, dsr_in});
        rem_d  = rem_q;
        dsr_d  = dsr_q;
        qs_d   = qs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done   = 1'b0;
        if (start) begin
            cnt_d  = CW'(QW - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done   = 1'b1;
            end
        end
        // Dividend bits shift out of the top of qs while quotient bits enter at the bottom.
        if (start || busy_q) begin
            rem_d = ge ? DW'(trial - {1'b0, dsr_in}) : trial[DW-1:0];
            qs_d  = {qs_in[QW-2:0], ge};
            dsr_d = dsr_in;
        end
    end

    assign quot = qs_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            dsr_q  <= '0;
            qs_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            qs_q   <= qs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/cdiv.sv
// Complex fixed-point divider q = a/b with a fixed-latency serial datapath.
// Define CDIV_ROUND_EN for round-half-away-from-zero (one extra quotient bit, +1 cycle).
module cdiv
    import cdiv_pkg::*;
#(
    parameter int AWIDTH = 16,
    parameter int BWIDTH = 16,
    parameter int FRAC   = 12,
    parameter int OWIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [AWIDTH-1:0] ar,
    input  logic signed [AWIDTH-1:0] ai,
    input  logic signed [BWIDTH-1:0] br,
    input  logic signed [BWIDTH-1:0] bi,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OWIDTH-1:0] qr,
    output logic signed [OWIDTH-1:0] qi,
    output logic                     div_zero,
    output logic                     sat
);
`ifdef CDIV_ROUND_EN
    localparam int XB = 1;
`else
    localparam int XB = 0;
`endif
    localparam int NW = nw_f(AWIDTH, BWIDTH);
    localparam int DW = 2 * BWIDTH;
    localparam int QW = iter_f(NW, FRAC, XB);
    localparam logic [63:0]       POS64   = sat_pos_f(OWIDTH);
    localparam logic [63:0]       NEG64   = sat_neg_f(OWIDTH);
    localparam logic [OWIDTH-1:0] SAT_POS = POS64[OWIDTH-1:0];
    localparam logic [OWIDTH-1:0] SAT_NEG = NEG64[OWIDTH-1:0];
    localparam logic [QW:0]       LIM     = (QW + 1)'(1) << (OWIDTH - 1);

    state_e state_q, state_d;
    logic in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic signed [AWIDTH-1:0] ar_q, ar_d, ai_q, ai_d;
    logic signed [BWIDTH-1:0] br_q, br_d, bi_q, bi_d;
    logic signed [NW-1:0] nr_q, nr_d, ni_q, ni_d;
    logic signed [DW-1:0] br_w, bi_w;
    logic neg_r_q, neg_r_d, neg_i_q, neg_i_d, dz_q, dz_d;
    logic [OWIDTH-1:0] qr_q, qr_d, qi_q, qi_d, res_r, res_i;
    logic div_zero_q, div_zero_d, sat_q, sat_d, sat_r, sat_i;
    logic [DW-1:0] den;
    logic [NW-1:0] mag_r, mag_i;
    logic [QW-1:0] quot_r, quot_i;
    logic start, done_r, done_i;

    // Returns {saturated, signed result} for one component.
    function automatic logic [OWIDTH:0] fin_f(input logic neg, input logic [QW-1:0] q);
        logic [QW:0] m;
`ifdef CDIV_ROUND_EN
        m = ({1'b0, q} + (QW + 1)'(1)) >> 1;
`else
        m = {1'b0, q};
`endif
        if (m >= LIM) return {1'b1, neg ? SAT_NEG : SAT_POS};
        return {1'b0, neg ? -m[OWIDTH-1:0] : m[OWIDTH-1:0]};
    endfunction

    always_comb begin
        br_w  = DW'(br_q);
        bi_w  = DW'(bi_q);
        den   = br_w * br_w + bi_w * bi_w;
        mag_r = nr_q[NW-1] ? -nr_q : nr_q;
        mag_i = ni_q[NW-1] ? -ni_q : ni_q;
        start = (state_q == S_PREP);
    end

    cdiv_udiv #(.NW(NW), .DW(DW), .SH(FRAC + XB)) u_div_r (
        .clk(clk), .rst(rst), .start(start), .dividend(mag_r), .divisor(den),
        .done(done_r), .quot(quot_r)
    );

    cdiv_udiv #(.NW(NW), .DW(DW), .SH(FRAC + XB)) u_div_i (
        .clk(clk), .rst(rst), .start(start), .dividend(mag_i), .divisor(den),
        .done(done_i), .quot(quot_i)
    );

    always_comb begin
        state_d = state_q;   in_ready_d = in_ready_q; out_valid_d = out_valid_q;
        ar_d = ar_q;         ai_d = ai_q;             br_d = br_q;   bi_d = bi_q;
        nr_d = nr_q;         ni_d = ni_q;
        neg_r_d = neg_r_q;   neg_i_d = neg_i_q;       dz_d = dz_q;
        qr_d = qr_q;         qi_d = qi_q;             div_zero_d = div_zero_q; sat_d = sat_q;
        {sat_r, res_r} = fin_f(neg_r_q, quot_r);
        {sat_i, res_i} = fin_f(neg_i_q, quot_i);
        case (state_q)
            S_IDLE: if (in_valid && in_ready_q) begin
                ar_d = ar; ai_d = ai; br_d = br; bi_d = bi;
                in_ready_d = 1'b0;
                state_d    = S_MULT;
            end
            S_MULT: begin
                nr_d    = NW'(ar_q) * NW'(br_q) + NW'(ai_q) * NW'(bi_q);
                ni_d    = NW'(ai_q) * NW'(br_q) - NW'(ar_q) * NW'(bi_q);
                state_d = S_PREP;
            end
            S_PREP: begin
                neg_r_d = nr_q[NW-1];
                neg_i_d = ni_q[NW-1];
                dz_d    = (den == '0);
                state_d = S_DIV;
            end
            S_DIV: if (done_r && done_i) begin
                out_valid_d = 1'b1;
                div_zero_d  = dz_q;
                qr_d        = dz_q ? '0 : res_r;
                qi_d        = dz_q ? '0 : res_i;
                sat_d       = !dz_q && (sat_r || sat_i);
                state_d     = S_DONE;
            end
            S_DONE: if (out_ready) begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE; in_ready_q <= 1'b1; out_valid_q <= 1'b0;
            ar_q <= '0; ai_q <= '0; br_q <= '0; bi_q <= '0;
            nr_q <= '0; ni_q <= '0;
            neg_r_q <= 1'b0; neg_i_q <= 1'b0; dz_q <= 1'b0;
            qr_q <= '0; qi_q <= '0; div_zero_q <= 1'b0; sat_q <= 1'b0;
        end else begin
            state_q <= state_d; in_ready_q <= in_ready_d; out_valid_q <= out_valid_d;
            ar_q <= ar_d; ai_q <= ai_d; br_q <= br_d; bi_q <= bi_d;
            nr_q <= nr_d; ni_q <= ni_d;
            neg_r_q <= neg_r_d; neg_i_q <= neg_i_d; dz_q <= dz_d;
            qr_q <= qr_d; qi_q <= qi_d; div_zero_q <= div_zero_d; sat_q <= sat_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign qr        = qr_q;
    assign qi        = qi_q;
    assign div_zero  = div_zero_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_cdiv.sv
// Self-checking bench for cdiv: directed vectors, random ops against an arithmetic model,
// back-pressure, and reset abort.
module tb_cdiv;
    localparam int AW = 16, BW = 16, FR = 12, OW = 24;
`ifdef CDIV_ROUND_EN
    localparam int              LAT = 48;
    localparam logic [OW-1:0]   Q23 = 24'd2731;
`else
    localparam int              LAT = 47;
    localparam logic [OW-1:0]   Q23 = 24'd2730;
`endif

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready, div_zero, sat;
    logic signed [AW-1:0] ar, ai;
    logic signed [BW-1:0] br, bi;
    logic signed [OW-1:0] qr, qi;
    int n_tests = 0;
    int n_fail  = 0;

    cdiv #(.AWIDTH(AW), .BWIDTH(BW), .FRAC(FR), .OWIDTH(OW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ar(ar), .ai(ai), .br(br), .bi(bi),
        .out_valid(out_valid), .out_ready(out_ready),
        .qr(qr), .qi(qi), .div_zero(div_zero), .sat(sat)
    );

    always #5 clk = ~clk;

    function automatic void model_comp(input longint n, input longint den,
                                       output logic [OW-1:0] v, output logic s);
        longint m, q, lim;
        m = (n < 0) ? -n : n;
`ifdef CDIV_ROUND_EN
        q = ((m * (longint'(1) << (FR + 1))) / den + 1) / 2;
`else
        q = (m * (longint'(1) << FR)) / den;
`endif
        lim = longint'(1) << (OW - 1);
        s = (q >= lim);
        if (s) v = (n < 0) ? OW'(-lim) : OW'(lim - 1);
        else   v = (n < 0) ? OW'(-q)   : OW'(q);
    endfunction

    function automatic void model(input logic signed [AW-1:0] xar, xai,
                                  input logic signed [BW-1:0] xbr, xbi,
                                  output logic [OW-1:0] eqr, eqi, output logic edz, esat);
        longint nr, ni, den;
        logic sr, si;
        nr  = longint'(xar) * longint'(xbr) + longint'(xai) * longint'(xbi);
        ni  = longint'(xai) * longint'(xbr) - longint'(xar) * longint'(xbi);
        den = longint'(xbr) * longint'(xbr) + longint'(xbi) * longint'(xbi);
        if (den == 0) begin
            eqr = '0; eqi = '0; edz = 1'b1; esat = 1'b0;
        end else begin
            model_comp(nr, den, eqr, sr);
            model_comp(ni, den, eqi, si);
            edz  = 1'b0;
            esat = sr | si;
        end
    endfunction

    // Drives one operation; lat counts edges from the accept edge (inclusive) to out_valid, -1 on timeout.
    task automatic do_op(input logic signed [AW-1:0] xar, xai, input logic signed [BW-1:0] xbr, xbi,
                         output logic [OW-1:0] gqr, gqi, output logic gdz, gsat, output int lat);
        int w;
        @(negedge clk);
        ar = xar; ai = xai; br = xbr; bi = xbi; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin @(negedge clk); w++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        if (!out_valid) lat = -1;
        gqr = qr; gqi = qi; gdz = div_zero; gsat = sat;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        ar = '0; ai = '0; br = '0; bi = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_during got=%b want=1", in_ready); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_handshake got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        n_tests++;
        if (qr !== '0 || qi !== '0 || div_zero !== 1'b0 || sat !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs got qr=%0d qi=%0d dz=%b sat=%b want 0/0/0/0", qr, qi, div_zero, sat);
        end
    endtask

    task automatic test_directed();
        logic [OW-1:0] gqr, gqi; logic gdz, gsat; int lat;
        do_op(16'sd3, 16'sd4, 16'sd1, 16'sd2, gqr, gqi, gdz, gsat, lat);
        n_tests++;
        if (gqr !== 24'd9011 || gqi !== -24'sd1638 || gdz !== 1'b0 || gsat !== 1'b0 || lat !== LAT) begin
            n_fail++; $display("FAIL basic_34_12 got qr=%0d qi=%0d dz=%b sat=%b lat=%0d want 9011/-1638/0/0/%0d",
                               $signed(gqr), $signed(gqi), gdz, gsat, lat, LAT);
        end
        do_op(16'sd2, 16'sd0, 16'sd3, 16'sd0, gqr, gqi, gdz, gsat, lat);
        n_tests++;
        if (gqr !== Q23 || gqi !== '0 || gsat !== 1'b0 || lat !== LAT) begin
            n_fail++; $display("FAIL two_thirds got qr=%0d qi=%0d sat=%b lat=%0d want %0d/0/0/%0d",
                               $signed(gqr), $signed(gqi), gsat, lat, Q23, LAT);
        end
        do_op(16'sd5, -16'sd7, 16'sd0, 16'sd0, gqr, gqi, gdz, gsat, lat);
        n_tests++;
        if (gqr !== '0 || gqi !== '0 || gdz !== 1'b1 || gsat !== 1'b0 || lat !== LAT) begin
            n_fail++; $display("FAIL div_zero got qr=%0d qi=%0d dz=%b sat=%b lat=%0d want 0/0/1/0/%0d",
                               $signed(gqr), $signed(gqi), gdz, gsat, lat, LAT);
        end
        do_op(16'sd32767, -16'sd32768, 16'sd1, 16'sd0, gqr, gqi, gdz, gsat, lat);
        n_tests++;
        if (gqr !== 24'd8388607 || gqi !== 24'h800000 || gdz !== 1'b0 || gsat !== 1'b1) begin
            n_fail++; $display("FAIL saturate got qr=%0d qi=%0d dz=%b sat=%b want 8388607/-8388608/0/1",
                               $signed(gqr), $signed(gqi), gdz, gsat);
        end
    endtask

    task automatic test_random();
        logic signed [AW-1:0] xar, xai; logic signed [BW-1:0] xbr, xbi;
        logic [OW-1:0] gqr, gqi, eqr, eqi; logic gdz, gsat, edz, esat; int lat;
        for (int k = 0; k < 40; k++) begin
            xar = AW'($urandom); xai = AW'($urandom);
            case (k % 4)
                0: begin xbr = BW'($urandom); xbi = BW'($urandom); end
                1: begin xbr = BW'($urandom_range(0, 600)) - 16'sd300; xbi = BW'($urandom_range(0, 600)) - 16'sd300; end
                2: begin xbr = BW'($urandom_range(0, 6)) - 16'sd3; xbi = BW'($urandom_range(0, 6)) - 16'sd3; end
                default: begin xbr = -16'sd32768; xbi = BW'($urandom); xar = AW'($urandom_range(0, 200)); end
            endcase
            if (k == 17) begin xbr = '0; xbi = '0; end
            model(xar, xai, xbr, xbi, eqr, eqi, edz, esat);
            do_op(xar, xai, xbr, xbi, gqr, gqi, gdz, gsat, lat);
            n_tests++;
            if (gqr !== eqr || gqi !== eqi) begin
                n_fail++; $display("FAIL rand_q[%0d] a=(%0d,%0d) b=(%0d,%0d) got %0d,%0d want %0d,%0d", k,
                                   xar, xai, xbr, xbi, $signed(gqr), $signed(gqi), $signed(eqr), $signed(eqi));
            end
            n_tests++;
            if (gdz !== edz || gsat !== esat || lat !== LAT) begin
                n_fail++; $display("FAIL rand_flags[%0d] got dz=%b sat=%b lat=%0d want %b/%b/%0d",
                                   k, gdz, gsat, lat, edz, esat, LAT);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [OW-1:0] gqr, gqi; logic gdz, gsat; int lat; int bad;
        out_ready = 1'b0;
        do_op(16'sd3, 16'sd4, 16'sd1, 16'sd2, gqr, gqi, gdz, gsat, lat);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b1; ar = AW'($urandom); ai = AW'($urandom); br = BW'($urandom); bi = BW'($urandom);
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || qr !== 24'sd9011 || qi !== -24'sd1638
                || div_zero !== 1'b0 || sat !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL hold_stall bad_cycles=%0d want 0", bad); end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        n_tests++;
        if (qr !== 24'sd9011 || qi !== -24'sd1638) begin
            n_fail++; $display("FAIL keep_after got qr=%0d qi=%0d want 9011/-1638", qr, qi);
        end
        do_op(16'sd2, 16'sd0, 16'sd3, 16'sd0, gqr, gqi, gdz, gsat, lat);
        n_tests++;
        if (gqr !== Q23 || lat !== LAT) begin
            n_fail++; $display("FAIL after_stall got qr=%0d lat=%0d want %0d/%0d", $signed(gqr), lat, Q23, LAT);
        end
    endtask

    task automatic test_abort();
        logic [OW-1:0] gqr, gqi, eqr, eqi; logic gdz, gsat, edz, esat; int lat; bit seen;
        @(negedge clk);
        ar = 16'sd1000; ai = 16'sd2000; br = 16'sd3; bi = 16'sd4; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL busy_in_ready got=%b want 0", in_ready); end
        repeat (10) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL abort_reset got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        n_tests++;
        if (seen) begin n_fail++; $display("FAIL abort_no_result got out_valid=1 want 0"); end
        model(-16'sd1234, 16'sd567, 16'sd89, -16'sd10, eqr, eqi, edz, esat);
        do_op(-16'sd1234, 16'sd567, 16'sd89, -16'sd10, gqr, gqi, gdz, gsat, lat);
        n_tests++;
        if (gqr !== eqr || gqi !== eqi || gsat !== esat || lat !== LAT) begin
            n_fail++; $display("FAIL after_abort got %0d,%0d sat=%b lat=%0d want %0d,%0d/%b/%0d",
                               $signed(gqr), $signed(gqi), gsat, lat, $signed(eqr), $signed(eqi), esat, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
